// File: rtl/mux8_pkg.sv
// Shared constants and types for the 8-to-1 collecting multiplexer.
package mux8_pkg;
  localparam int N_CH  = 8;
  localparam int SEL_W = 3;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux8_collector_arb.sv
// rr_arb8: combinational 8-way arbiter, search starts at ptr and wraps mod 8.
import mux8_pkg::*;

module rr_arb8 (
  input  logic [N_CH-1:0] req,
  input  sel_t            ptr,
  input  logic            en,
  output logic [N_CH-1:0] gnt_onehot,
  output sel_t            gnt_idx,
  output logic            any
);
  sel_t idx;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = ptr + sel_t'(k);
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
    // en withholds the grant without disturbing the index search
    gnt_onehot = (any && en) ? (N_CH'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/mux8_collector.sv
// mux8_collector: registered 8-to-1 collector with source tag.
// `define MUX8_COLLECTOR_RR_EN for round-robin; default is fixed priority (lowest index).
import mux8_pkg::*;

module mux8_collector #(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      in_valid,
  input  logic [8*W-1:0]  in_data,
  output logic [7:0]      in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [2:0]      out_sel
);
  logic         out_valid_q;
  logic [W-1:0] out_data_q;
  sel_t         out_sel_q;
  sel_t         ptr;
  sel_t         gnt_idx;
  logic         gnt_any;
  logic         load_ok;
  logic         xfer;

  assign load_ok = !out_valid_q || out_ready;

  rr_arb8 u_arb (
    .req        (in_valid),
    .ptr        (ptr),
    .en         (load_ok && rst_n),
    .gnt_onehot (in_ready),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  assign xfer = gnt_any && load_ok && rst_n;

`ifdef MUX8_COLLECTOR_RR_EN
  sel_t ptr_q, ptr_d;
  assign ptr_d = xfer ? sel_t'(gnt_idx + 3'd1) : ptr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= in_data[gnt_idx*W +: W];
      out_sel_q   <= gnt_idx;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux8_collector.sv
// Directed self-checking bench for mux8_collector (either arbitration build).
module tb_mux8_collector;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     in_valid;
  logic [8*W-1:0] in_data;
  logic [7:0]     in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;

  int n_chk = 0;
  int n_fail = 0;

  mux8_collector #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_data();
    for (int i = 0; i < 8; i++) in_data[i*W +: W] = 8'h10 + 8'(i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
    fill_data();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 8'hFF; out_ready = 1'b1;
    fill_data();
    #1;
    n_chk++;
    if (in_ready !== 8'h00) begin n_fail++; $display("FAIL reset_in_ready got=%h exp=00", in_ready); end
    step();
    rst_n = 1'b1; in_valid = 8'h01;
    step();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'h10) begin
      n_fail++; $display("FAIL pre_reset_load got=%b/%h exp=1/10", out_valid, out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 3'd0 || in_ready !== 8'h00) begin
      n_fail++; $display("FAIL async_reset got=%b/%h/%0d/%h exp=0/00/0/00", out_valid, out_data, out_sel, in_ready);
    end
    #1 rst_n = 1'b1; in_valid = 8'h0A;
    #1;
    n_chk++;
    if (in_ready !== 8'h02) begin n_fail++; $display("FAIL post_reset_grant got=%h exp=02", in_ready); end
    step();
    n_chk++;
    if (out_valid !== 1'b1 || out_sel !== 3'd1 || out_data !== 8'h11) begin
      n_fail++; $display("FAIL post_reset_word got=%b/%0d/%h exp=1/1/11", out_valid, out_sel, out_data);
    end
    in_valid = '0;
    step();
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1; in_valid = 8'h20; in_data[5*W +: W] = 8'hA5;
    #1;
    n_chk++;
    if (in_ready !== 8'h20) begin n_fail++; $display("FAIL single_in_ready got=%h exp=20", in_ready); end
    step();
    in_valid = '0;
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 3'd5) begin
      n_fail++; $display("FAIL single_word got=%b/%h/%0d exp=1/a5/5", out_valid, out_data, out_sel);
    end
    step();
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_sel !== 3'd5) begin
      n_fail++; $display("FAIL drain_hold got=%b/%h/%0d exp=0/a5/5", out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_fairness();
    logic [2:0] exp;
    do_reset();
    out_ready = 1'b1; in_valid = 8'hFF;
    for (int c = 0; c < 9; c++) begin
`ifdef MUX8_COLLECTOR_RR_EN
      exp = 3'(c % 8);
`else
      exp = 3'd0;
`endif
      #1;
      n_chk++;
      if (in_ready !== (8'h01 << exp)) begin
        n_fail++; $display("FAIL fair_in_ready[%0d] got=%h exp=%h", c, in_ready, 8'h01 << exp);
      end
      step();
      n_chk++;
      if (out_valid !== 1'b1 || out_sel !== exp || out_data !== (8'h10 + 8'(exp))) begin
        n_fail++; $display("FAIL fair_word[%0d] got=%b/%0d/%h exp=1/%0d/%h", c, out_valid, out_sel, out_data, exp, 8'h10 + 8'(exp));
      end
    end
    in_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; in_valid = 8'h01;
    step();
    in_valid = 8'h0C;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++;
      if (in_ready !== 8'h00) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%h exp=00", c, in_ready); end
      step();
      n_chk++;
      if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== 8'h10) begin
        n_fail++; $display("FAIL bp_hold[%0d] got=%b/%0d/%h exp=1/0/10", c, out_valid, out_sel, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 8'h04) begin n_fail++; $display("FAIL bp_release_ready got=%h exp=04", in_ready); end
    step();
    n_chk++;
    if (out_valid !== 1'b1 || out_sel !== 3'd2 || out_data !== 8'h12) begin
      n_fail++; $display("FAIL bp_first got=%b/%0d/%h exp=1/2/12", out_valid, out_sel, out_data);
    end
    step();
    n_chk++;
`ifdef MUX8_COLLECTOR_RR_EN
    if (out_valid !== 1'b1 || out_sel !== 3'd3 || out_data !== 8'h13) begin
      n_fail++; $display("FAIL bp_second got=%b/%0d/%h exp=1/3/13", out_valid, out_sel, out_data);
    end
`else
    if (out_valid !== 1'b1 || out_sel !== 3'd2 || out_data !== 8'h12) begin
      n_fail++; $display("FAIL bp_second got=%b/%0d/%h exp=1/2/12", out_valid, out_sel, out_data);
    end
`endif
    in_valid = '0;
    step();
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_wrap();
    logic [2:0] exp;
    do_reset();
    out_ready = 1'b1; in_valid = 8'h40;
    step();
    n_chk++;
    if (out_sel !== 3'd6) begin n_fail++; $display("FAIL wrap_setup got=%0d exp=6", out_sel); end
    in_valid = 8'h81;
    for (int c = 0; c < 4; c++) begin
`ifdef MUX8_COLLECTOR_RR_EN
      exp = (c % 2 == 0) ? 3'd7 : 3'd0;
`else
      exp = 3'd0;
`endif
      step();
      n_chk++;
      if (out_valid !== 1'b1 || out_sel !== exp) begin
        n_fail++; $display("FAIL wrap_sel[%0d] got=%b/%0d exp=1/%0d", c, out_valid, out_sel, exp);
      end
    end
    in_valid = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
